// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Hazard and stall controller for a five-stage MIPS-style pipeline with a
// multi-cycle multiply/divide unit and CP0 exception redirect.
//
// The controller compares the registers read by the D-stage instruction
// against the destinations of the instructions in E and M. If an operand is
// needed before its producer can forward it, D and PC are frozen and a
// bubble is pushed into E.
//
// A small FSM tracks the multiply/divide unit. While the unit is busy, any
// D-stage md instruction is held back. A pending exception (req) overrides
// every stall so the pipeline registers can flush and redirect.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   D_rs, D_rt            source register numbers of the D instruction
//   D_tuse_rs, D_tuse_rt  cycles until each operand is consumed (3 = unused)
//   E_waddr, M_waddr      destination register in E / M (0 = no write)
//   E_tnew, M_tnew        cycles until the E / M result exists (0 = ready)
//   D_md                  D instruction uses the multiply/divide unit
//   E_md_start            01 mult start, 10 div start, 00/11 nothing
//   int_req               exception/interrupt request from CP0 in M
//   pc_en, d_en           PC and D-register write enables
//   e_flush               bubble into the E register
//   req                   exception redirect to every pipeline register
//   stall                 combined stall indication
//   md_busy, md_cnt       multiply/divide unit busy flag and remaining cycles
//   stall_cnt             saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic [4:0]  E_waddr,
  input  logic [4:0]  M_waddr,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        D_md,
  input  logic [1:0]  E_md_start,
  input  logic        int_req,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_flush,
  output logic        req,
  output logic        stall,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } md_state_t;

  localparam logic [1:0]  START_MULT = 2'b01;
  localparam logic [1:0]  START_DIV  = 2'b10;
  localparam logic [3:0]  MULT_CYCLES = 4'd5;
  localparam logic [3:0]  DIV_CYCLES  = 4'd10;
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  md_state_t state;

  logic rs_hit;
  logic rt_hit;
  logic md_hit;
  logic md_starting;

  // Data hazard detection. A hazard exists only when the producer's result
  // arrives later than the consumer needs it (tuse < tnew). Register zero is
  // hard-wired, so it never creates a dependency. tuse=3 never stalls,
  // because tnew is at most 3.
  always_comb begin
    rs_hit = (D_rs != 5'd0) &&
             (((D_rs == E_waddr) && (D_tuse_rs < E_tnew)) ||
              ((D_rs == M_waddr) && (D_tuse_rs < M_tnew)));
    rt_hit = (D_rt != 5'd0) &&
             (((D_rt == E_waddr) && (D_tuse_rt < E_tnew)) ||
              ((D_rt == M_waddr) && (D_tuse_rt < M_tnew)));
  end

  // Structural hazard on the multiply/divide unit. A start sitting in E
  // blocks a D-stage md instruction in the same cycle, before md_busy has
  // had a chance to rise. The reserved code 11 counts as no start.
  always_comb begin
    md_starting = (E_md_start == START_MULT) || (E_md_start == START_DIV);
    md_hit      = D_md && (md_busy || md_starting);
  end

  // Stall and redirect steering. An exception cancels the instructions in D
  // and E anyway, so holding them would only delay the redirect. req
  // therefore masks every stall, which leaves PC and D enabled so the
  // redirect target can load.
  always_comb begin
    req     = int_req;
    stall   = (rs_hit || rt_hit || md_hit) && !int_req;
    pc_en   = !stall;
    d_en    = !stall;
    e_flush = stall;
  end

  // Multiply/divide busy tracker. A start is accepted only from IDLE and
  // only when the E instruction is not being cancelled by req. Once the
  // unit is running, it always counts down to completion, because the
  // hardware unit cannot be aborted mid-operation. The edge that takes
  // md_cnt from 1 to 0 returns to IDLE. md_busy is kept as its own register
  // so that it is glitch-free and matches the state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      md_cnt  <= 4'd0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!int_req && (E_md_start == START_MULT)) begin
            state   <= MULT;
            md_cnt  <= MULT_CYCLES;
            md_busy <= 1'b1;
          end else if (!int_req && (E_md_start == START_DIV)) begin
            state   <= DIV;
            md_cnt  <= DIV_CYCLES;
            md_busy <= 1'b1;
          end
        end
        MULT, DIV: begin
          if (md_cnt <= 4'd1) begin
            state   <= IDLE;
            md_cnt  <= 4'd0;
            md_busy <= 1'b0;
          end else begin
            md_cnt <= md_cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          md_cnt  <= 4'd0;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter for stalled cycles. It holds at its maximum instead
  // of wrapping, so a long run never reads back as a small number. req
  // cycles are excluded automatically, because stall is forced low during
  // req.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Scoreboard bench for pipe_ctrl.
//
// The stimulus process drives one directed vector per cycle, just after the
// rising edge. For each vector it pushes the hand-computed response into a
// queue. The stall_cnt expectation comes from a small saturating model of
// the stall history.
//
// A separate monitor pops one entry on every falling edge while entries are
// pending, and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  typedef struct packed {
    logic       reset;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_tuse_rs;
    logic [1:0] D_tuse_rt;
    logic [4:0] E_waddr;
    logic [4:0] M_waddr;
    logic [1:0] E_tnew;
    logic [1:0] M_tnew;
    logic       D_md;
    logic [1:0] E_md_start;
    logic       int_req;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        md_busy;
    logic [3:0]  md_cnt;
    logic [15:0] stall_cnt;
    logic        check_regs;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic [4:0]  E_waddr;
  logic [4:0]  M_waddr;
  logic [1:0]  E_tnew;
  logic [1:0]  M_tnew;
  logic        D_md;
  logic [1:0]  E_md_start;
  logic        int_req;
  logic        pc_en;
  logic        d_en;
  logic        e_flush;
  logic        req;
  logic        stall;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [15:0] stall_cnt;

  exp_t  exp_q[$];
  string name_q[$];

  int          cmp_count = 0;
  int          err_count = 0;
  logic [15:0] exp_stall_cnt = 16'd0;

  pipe_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .E_waddr    (E_waddr),
    .M_waddr    (M_waddr),
    .E_tnew     (E_tnew),
    .M_tnew     (M_tnew),
    .D_md       (D_md),
    .E_md_start (E_md_start),
    .int_req    (int_req),
    .pc_en      (pc_en),
    .d_en       (d_en),
    .e_flush    (e_flush),
    .req        (req),
    .stall      (stall),
    .md_busy    (md_busy),
    .md_cnt     (md_cnt),
    .stall_cnt  (stall_cnt)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiet vector: no reset, no hazards, both operands unused.
  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.D_tuse_rs = 2'd3;
    s.D_tuse_rt = 2'd3;
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    reset      = s.reset;
    D_rs       = s.D_rs;
    D_rt       = s.D_rt;
    D_tuse_rs  = s.D_tuse_rs;
    D_tuse_rt  = s.D_tuse_rt;
    E_waddr    = s.E_waddr;
    M_waddr    = s.M_waddr;
    E_tnew     = s.E_tnew;
    M_tnew     = s.M_tnew;
    D_md       = s.D_md;
    E_md_start = s.E_md_start;
    int_req    = s.int_req;
  endtask

  // Advance the stall-history model by one edge.
  task automatic updateModel(input stim_t s, input logic exp_stall);
    if (s.reset) exp_stall_cnt = 16'd0;
    else if (exp_stall && exp_stall_cnt != 16'hFFFF) exp_stall_cnt = exp_stall_cnt + 16'd1;
  endtask

  // Drive one vector for one cycle and queue its expected response.
  task automatic applyStimulus(input stim_t s, input string name, input logic exp_stall,
                               input logic exp_busy, input logic [3:0] exp_cnt,
                               input logic check_regs);
    exp_t e;
    @(posedge clk);
    #1;
    driveInputs(s);
    e.stall      = exp_stall;
    e.req        = s.int_req;
    e.md_busy    = exp_busy;
    e.md_cnt     = exp_cnt;
    e.stall_cnt  = exp_stall_cnt;
    e.check_regs = check_regs;
    exp_q.push_back(e);
    name_q.push_back(name);
    updateModel(s, exp_stall);
  endtask

  // Drive a vector without queuing a check. Used for the long saturation run.
  task automatic driveOnly(input stim_t s, input logic exp_stall);
    @(posedge clk);
    #1;
    driveInputs(s);
    updateModel(s, exp_stall);
  endtask

  task automatic compareField(input string vec, input string what,
                              input logic [15:0] act, input logic [15:0] expv);
    cmp_count++;
    if (act !== expv) begin
      err_count++;
      $display("[TB] FAIL %s/%s: got %0h, expected %0h", vec, what, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string vec);
    compareField(vec, "stall",   {15'd0, stall},   {15'd0, e.stall});
    compareField(vec, "pc_en",   {15'd0, pc_en},   {15'd0, ~e.stall});
    compareField(vec, "d_en",    {15'd0, d_en},    {15'd0, ~e.stall});
    compareField(vec, "e_flush", {15'd0, e_flush}, {15'd0, e.stall});
    compareField(vec, "req",     {15'd0, req},     {15'd0, e.req});
    if (e.check_regs) begin
      compareField(vec, "md_busy",   {15'd0, md_busy}, {15'd0, e.md_busy});
      compareField(vec, "md_cnt",    {12'd0, md_cnt},  {12'd0, e.md_cnt});
      compareField(vec, "stall_cnt", stall_cnt,        e.stall_cnt);
    end
  endtask

  // Monitor: one expected entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front(), name_q.pop_front());
    end
  end

  // Hard time limit, so that a stuck run still ends.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    stim_t ld;

    s = idleStim();
    s.reset = 1'b1;
    driveInputs(s);

    // The first edge already sees reset=1. The second reset cycle verifies
    // the cleared registers.
    applyStimulus(s, "reset_first", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(s, "reset_state", 1'b0, 1'b0, 4'd0, 1'b1);

    s = idleStim();
    applyStimulus(s, "idle", 1'b0, 1'b0, 4'd0, 1'b1);

    // Load-use case on rs against E.
    ld = idleStim();
    ld.D_rs = 5'd5;
    ld.D_tuse_rs = 2'd0;
    ld.E_waddr = 5'd5;
    ld.E_tnew = 2'd2;
    applyStimulus(ld, "load_use", 1'b1, 1'b0, 4'd0, 1'b1);

    s = ld;
    s.E_tnew = 2'd1;
    s.D_tuse_rs = 2'd1;
    applyStimulus(s, "tuse_eq_tnew1", 1'b0, 1'b0, 4'd0, 1'b1);

    // Register zero never stalls.
    s = idleStim();
    s.D_tuse_rs = 2'd0;
    s.E_tnew = 2'd2;
    applyStimulus(s, "reg_zero", 1'b0, 1'b0, 4'd0, 1'b1);

    // rt against M.
    s = idleStim();
    s.D_rt = 5'd7;
    s.D_tuse_rt = 2'd1;
    s.M_waddr = 5'd7;
    s.M_tnew = 2'd2;
    applyStimulus(s, "rt_m_hit", 1'b1, 1'b0, 4'd0, 1'b1);

    // tuse=3 never stalls, even against tnew=3.
    s.D_tuse_rt = 2'd3;
    s.M_tnew = 2'd3;
    applyStimulus(s, "rt_unused", 1'b0, 1'b0, 4'd0, 1'b1);

    s = idleStim();
    s.D_rs = 5'd9;
    s.D_tuse_rs = 2'd2;
    s.E_waddr = 5'd9;
    s.E_tnew = 2'd2;
    applyStimulus(s, "tuse_eq_tnew2", 1'b0, 1'b0, 4'd0, 1'b1);

    s.E_waddr = 5'd10;
    s.E_tnew = 2'd3;
    s.D_tuse_rs = 2'd0;
    applyStimulus(s, "other_reg", 1'b0, 1'b0, 4'd0, 1'b1);

    // A hazard during req must not stall or count.
    s = ld;
    s.int_req = 1'b1;
    applyStimulus(s, "hit_with_req", 1'b0, 1'b0, 4'd0, 1'b1);
    s = idleStim();
    applyStimulus(s, "after_req_cnt", 1'b0, 1'b0, 4'd0, 1'b1);

    // mult: the start cycle and 5 busy cycles stall a D-stage md instruction.
    s = idleStim();
    s.D_md = 1'b1;
    s.E_md_start = 2'b01;
    applyStimulus(s, "mult_c0", 1'b1, 1'b0, 4'd0, 1'b1);
    s.E_md_start = 2'b00;
    applyStimulus(s, "mult_c1", 1'b1, 1'b1, 4'd5, 1'b1);
    applyStimulus(s, "mult_c2", 1'b1, 1'b1, 4'd4, 1'b1);
    applyStimulus(s, "mult_c3", 1'b1, 1'b1, 4'd3, 1'b1);
    applyStimulus(s, "mult_c4", 1'b1, 1'b1, 4'd2, 1'b1);
    applyStimulus(s, "mult_c5", 1'b1, 1'b1, 4'd1, 1'b1);
    applyStimulus(s, "mult_c6", 1'b0, 1'b0, 4'd0, 1'b1);

    // Reserved start code does nothing.
    s.E_md_start = 2'b11;
    applyStimulus(s, "start_11", 1'b0, 1'b0, 4'd0, 1'b1);
    s = idleStim();
    applyStimulus(s, "start_11_after", 1'b0, 1'b0, 4'd0, 1'b1);

    // div start cancelled by a simultaneous req.
    s.E_md_start = 2'b10;
    s.int_req = 1'b1;
    applyStimulus(s, "div_with_req", 1'b0, 1'b0, 4'd0, 1'b1);
    s = idleStim();
    applyStimulus(s, "div_req_after", 1'b0, 1'b0, 4'd0, 1'b1);

    // A running div survives req.
    s.E_md_start = 2'b10;
    applyStimulus(s, "div_c0", 1'b0, 1'b0, 4'd0, 1'b1);
    s = idleStim();
    applyStimulus(s, "div_c1", 1'b0, 1'b1, 4'd10, 1'b1);
    s.D_md = 1'b1;
    applyStimulus(s, "div_c2_md", 1'b1, 1'b1, 4'd9, 1'b1);
    s = idleStim();
    applyStimulus(s, "div_c3", 1'b0, 1'b1, 4'd8, 1'b1);
    s.D_md = 1'b1;
    s.int_req = 1'b1;
    applyStimulus(s, "div_c4_req", 1'b0, 1'b1, 4'd7, 1'b1);
    s = idleStim();
    for (int i = 6; i >= 1; i--) begin
      applyStimulus(s, "div_tail", 1'b0, 1'b1, 4'(i), 1'b1);
    end
    applyStimulus(s, "div_done", 1'b0, 1'b0, 4'd0, 1'b1);

    // Reset aborts a running mult and wins over a concurrent start and stall.
    s.E_md_start = 2'b01;
    applyStimulus(s, "mult_r0", 1'b0, 1'b0, 4'd0, 1'b1);
    s = ld;
    s.reset = 1'b1;
    s.E_md_start = 2'b01;
    applyStimulus(s, "reset_mid_mult", 1'b1, 1'b1, 4'd5, 1'b1);
    s = idleStim();
    applyStimulus(s, "after_reset", 1'b0, 1'b0, 4'd0, 1'b1);

    // Saturation: 65540 stall cycles.
    for (int i = 0; i < 65540; i++) begin
      driveOnly(ld, 1'b1);
    end
    s = idleStim();
    applyStimulus(s, "sat_value", 1'b0, 1'b0, 4'd0, 1'b1);
    applyStimulus(ld, "sat_stall", 1'b1, 1'b0, 4'd0, 1'b1);
    applyStimulus(s, "sat_hold", 1'b0, 1'b0, 4'd0, 1'b1);
    s.reset = 1'b1;
    applyStimulus(s, "sat_reset", 1'b0, 1'b0, 4'd0, 1'b1);
    s = idleStim();
    applyStimulus(s, "sat_cleared", 1'b0, 1'b0, 4'd0, 1'b1);

    // Let the monitor drain the queue, with a bound.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      cmp_count++;
      err_count++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
